ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the Execute stage.
- Sits directly downstream of the ID/EX pipeline register. Consumes the forwarded rs1/rs2 operands and the M-extension op select from that register.
- Holds the pipeline through stall_req while it iterates. Returns a one-cycle-valid result that the EX result mux forwards into EX/MEM.

Parameters:
- XLEN, 32, operand/result width in bits.
- CNT_WIDTH, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a valid M-extension instruction.
- op  input  3  funct3 select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1  input  XLEN  forwarded rs1 operand.
- src2  input  XLEN  forwarded rs2 operand.
- flush  input  1  branch/exception flush of EX; aborts the current operation.
- stall_req  output  1  pipeline-hold request to the stall controller.
- done  output  1  result valid this cycle.
- result  output  XLEN  operation result.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, counter=0, all internal accumulators=0, done=0, result=0. stall_req=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0 at edge T: capture op, src1, src2 and operand signs into registers.
  - Special cases go IDLE->DONE at T+1. All other ops go to CALC with counter=0.
  - start=1 with flush=1: ignored, stay IDLE.
- CALC:
  - One radix-2 iteration per cycle, 32 cycles (counter 0..31).
  - Multiply: shift-add on |a|,|b| into a 2*XLEN product.
  - Divide: restoring shift-subtract on |dividend|,|divisor|.
  - At counter==31: apply sign correction, register result, go to DONE.
  - Normal latency: start sampled at T, done=1 during cycle T+33.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - start is not sampled in DONE. The instruction in ID/EX advances at the end of DONE.
- result holds its value after done until the next capture. Its value is only meaningful while done=1.
- stall_req (combinational) = (state==IDLE && start && !flush) || state==CALC. It is 0 in DONE.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Product sign = XOR of the operand signs that are treated as signed.
  - Quotient sign = XOR of the signs. Remainder sign = dividend sign.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Special cases, 1-cycle path to DONE:
  - Divisor==0: quotient=all ones; remainder=src1 (signed and unsigned).
  - Signed overflow, DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- flush in CALC or DONE: next state IDLE. done is forced to 0 in that cycle, and no result is committed.
- Reset asserted mid-operation: immediate return to the reset values above; no done pulse.
- Multiplication is not short-circuited for zero operands; it always takes 32 iterations.

Test Plan:
- MUL, src1=7, src2=0xFFFFFFFD, start at T -> stall_req=1 for T..T+32; done=1 at T+33 with result=0xFFFFFFEB.
- MULH, src1=src2=0x80000000 -> result=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU, src1=0xFFFFFFFF, src2=2 -> 0xFFFFFFFF.
- DIV, src1=0xFFFFFFF9 (-7), src2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU, src1=100, src2=7 -> 14. REMU with the same operands -> 2.
- DIVU src1=0x1234, src2=0 -> done at T+1, result=0xFFFFFFFF. REMU with the same operands -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1. REM with the same operands -> 0.
- Start DIV, then flush=1 at T+10 -> state IDLE at T+11, stall_req=0, no done.
- Back-to-back: a second MUL is presented while in DONE -> ignored in DONE, sampled in the following IDLE cycle, with a full 33-cycle latency.
- Reset: rst low at T+5 of a MUL -> done=0, result=0, stall_req=0 immediately; the next start after reset release behaves normally.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Radix-2 shift-add multiply and restoring divide, one step per cycle.
module ex_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              r_state;
    state_t              w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [XLEN-1:0]     r_acc;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_opb;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_s1_signed;
    logic                w_s2_signed;
    logic                w_neg1;
    logic                w_neg2;
    logic                w_neg_res;
    logic [XLEN-1:0]     w_abs1;
    logic [XLEN-1:0]     w_abs2;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_last;

    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_diff;
    logic [XLEN-1:0]     w_acc_nxt;
    logic [XLEN-1:0]     w_lo_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_final;

    assign w_accept    = (r_state == S_IDLE) && start && !flush;
    assign w_s1_signed = !(op == 3'd3 || op == 3'd5 || op == 3'd7);
    assign w_s2_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign w_neg1      = w_s1_signed && src1[XLEN-1];
    assign w_neg2      = w_s2_signed && src2[XLEN-1];
    assign w_abs1      = w_neg1 ? -src1 : src1;
    assign w_abs2      = w_neg2 ? -src2 : src2;
    // Remainder follows the dividend sign; every other result follows the XOR.
    assign w_neg_res   = (op[2] && op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    assign w_div_zero  = op[2] && (src2 == '0);
    assign w_ovf       = op[2] && !op[0] && (src1 == MIN_NEG) && (src2 == '1);
    assign w_special   = w_div_zero || w_ovf;
    assign w_last      = (r_cnt == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? src1 : '1;
        end else if (w_ovf) begin
            w_special_res = op[1] ? '0 : MIN_NEG;
        end
    end

    // r_acc holds the product high half / partial remainder, r_lo the multiplier / quotient.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_opb : {XLEN{1'b0}})};
        w_div_shift = {r_acc, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_acc_nxt   = r_acc;
        w_lo_nxt    = r_lo;
        if (r_op[2]) begin
            if (!w_div_diff[XLEN]) begin
                w_acc_nxt = w_div_diff[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_div_shift[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod     = {w_acc_nxt, w_lo_nxt};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_quo_fix  = r_neg ? -w_lo_nxt : w_lo_nxt;
        w_rem_fix  = r_neg ? -w_acc_nxt : w_acc_nxt;
        case (r_op)
            3'd0:             w_final = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_final = w_quo_fix;
            default:          w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_req = rst && (((r_state == S_IDLE) && start && !flush) || (r_state == S_CALC));
        done      = (r_state == S_DONE) && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_neg <= w_neg_res;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_lo  <= op[2] ? w_abs1 : w_abs2;
                        r_opb <= op[2] ? w_abs2 : w_abs1;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= w_acc_nxt;
                        r_lo  <= w_lo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors, expected results and done cycles queued,
// a negedge monitor pops and checks each done pulse.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] r;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    ex_muldiv_unit #(.XLEN(32), .CNT_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got result=%h at cycle %0d, required no done", result, cyc);
            end else begin
                e = exp_q.pop_front();
                if (result !== e.r || cyc != e.c) begin
                    n_err++;
                    $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d",
                             result, cyc, e.r, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // b2b=1: called at the done negedge; inputs presented during DONE must wait one cycle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input bit spec, input bit b2b);
        int c0;
        bit ok;
        if (!b2b) @(negedge clk);
        op = f; src1 = a; src2 = b; start = 1'b1;
        #1;
        if (b2b) begin
            check("stall_in_done", {31'd0, stall_req}, 32'd0);
            @(posedge clk); #1;
            check("stall_idle_start", {31'd0, stall_req}, 32'd1);
        end else begin
            check("stall_start", {31'd0, stall_req}, 32'd1);
        end
        @(posedge clk); #1;
        c0 = cyc;
        exp_q.push_back('{r: expv, c: c0 + (spec ? 0 : 32)});
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (!stall_req) ok = 1'b0;
            @(negedge clk);
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        check("stall_hold", {31'd0, ok}, 32'd1);
        check("stall_at_done", {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b1;
        flush = 1'b0;
        op    = 3'd0;
        src1  = '0;
        src2  = '0;
        repeat (2) @(negedge clk);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        start = 1'b0;
        rst   = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
        issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
        issue(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue(3'd0, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0);
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(3'd4, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0, 1'b0);
        issue(3'd6, 32'd20, 32'hFFFFFFFD, 32'd2, 1'b0, 1'b0);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);

        issue(3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(3'd7, 32'h1234, 32'd0, 32'h1234, 1'b1, 1'b0);
        issue(3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue(3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b1, 1'b0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);

        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);

        @(negedge clk);
        op = 3'd4; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("flush_no_done", {31'd0, seen}, 32'd0);

        @(negedge clk);
        op = 3'd0; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        #1;
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("reset_no_done", {31'd0, seen}, 32'd0);
        issue(3'd0, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
